// File: rtl/regfile_pkg.sv
// Shared defaults, address/data types and small helpers for the scoreboarded
// register file.
package regfile_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREGS  = 16;
  localparam int unsigned PC_IDX = 15;
  localparam int unsigned PEND_W = 2;
  localparam int unsigned AW     = $clog2(NREGS);

  typedef logic [AW-1:0]     reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // Number of asserted bits among two write-hit flags (0, 1 or 2).
  function automatic logic [1:0] popcount2(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/reg_pend_ctr.sv
// One pending-write counter: +1 on issue, -dec on writeback, clamped to
// [0, 2**PEND_W-1].
module reg_pend_ctr #(
  parameter int unsigned PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic [1:0]        dec,
  output logic [PEND_W-1:0] count,
  output logic              zero,
  output logic              full
);
  import regfile_pkg::*;

  localparam logic [PEND_W+1:0] MAX_EXT = {2'b00, {PEND_W{1'b1}}};

  logic [PEND_W-1:0] count_q, count_d;
  logic [PEND_W+1:0] sum, dec_ext, diff;

  always_comb begin
    sum     = {2'b00, count_q} + {{(PEND_W+1){1'b0}}, inc};
    dec_ext = {{PEND_W{1'b0}}, dec};
    diff    = sum - dec_ext;
    count_d = count_q;
    // Writes to a non-pending register floor at zero rather than wrapping.
    if (sum <= dec_ext) begin
      count_d = '0;
    end else if (diff > MAX_EXT) begin
      count_d = '1;
    end else begin
      count_d = diff[PEND_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);
  assign full  = (count_q == '1);

endmodule

// File: rtl/register_file_sb.sv
// Register file with NRD bypassed read ports, two write ports (B over A),
// a PC alias register and per-register pending-write scoreboard.
module register_file_sb #(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned NREGS  = regfile_pkg::NREGS,
  parameter int unsigned AW     = $clog2(NREGS),
  parameter int unsigned NRD    = 3,
  parameter int unsigned PC_IDX = regfile_pkg::PC_IDX,
  parameter int unsigned PEND_W = regfile_pkg::PEND_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     ra,
  output logic [NRD*DATA_W-1:0] rd,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic                  we_a,
  input  logic [AW-1:0]         wa_a,
  input  logic [DATA_W-1:0]     wd_a,
  input  logic                  we_b,
  input  logic [AW-1:0]         wa_b,
  input  logic [DATA_W-1:0]     wd_b,
  input  logic                  iss_v,
  input  logic [AW-1:0]         iss_rd,
  output logic                  iss_rdy,
  output logic [NREGS-1:0]      busy,
  output logic [NRD-1:0]        hazard
);
  import regfile_pkg::*;

  localparam logic [AW-1:0] PC_A = AW'(PC_IDX);
  localparam int unsigned   CW   = PEND_W + 1;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [PEND_W-1:0] cnt    [NREGS];
  logic [1:0]        dec    [NREGS];
  logic [NREGS-1:0]  inc, cnt_zero, cnt_full;
  logic              iss_hit;
  logic              fwd_a, fwd_b;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < NREGS;
  endfunction

  // Bypass is suppressed while reset is held so reads show the cleared state.
  assign fwd_a = we_a & rst;
  assign fwd_b = we_b & rst;

  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      regs_d[r] = regs_q[r];
      if (r != PC_IDX) begin
        if (we_b && 32'(wa_b) == r) begin
          regs_d[r] = wd_b;
        end else if (we_a && 32'(wa_a) == r) begin
          regs_d[r] = wd_a;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    iss_hit = (iss_rd != PC_A) && in_range(iss_rd);
    iss_rdy = !(iss_hit && cnt_full[iss_rd]);
    for (int unsigned r = 0; r < NREGS; r++) begin
      inc[r] = iss_v && iss_rdy && iss_hit && (32'(iss_rd) == r);
      if (r == PC_IDX) begin
        dec[r] = 2'b00;
      end else begin
        dec[r] = popcount2(we_a && 32'(wa_a) == r, we_b && 32'(wa_b) == r);
      end
    end
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_ctr
    reg_pend_ctr #(.PEND_W(PEND_W)) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc[r]),
      .dec   (dec[r]),
      .count (cnt[r]),
      .zero  (cnt_zero[r]),
      .full  (cnt_full[r])
    );
  end

  assign busy = ~cnt_zero;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]     a;
    logic              hit_a, hit_b;
    logic [1:0]        nwr;
    logic [PEND_W-1:0] cnt_a;
    logic [DATA_W-1:0] stored;

    assign a = ra[i*AW +: AW];

    always_comb begin
      hit_a  = fwd_a && (wa_a == a);
      hit_b  = fwd_b && (wa_b == a);
      nwr    = popcount2(hit_a, hit_b);
      cnt_a  = in_range(a) ? cnt[a] : '0;
      stored = in_range(a) ? regs_q[a] : '0;
      if (a == PC_A) begin
        rd[i*DATA_W +: DATA_W] = pc_in;
      end else if (hit_b) begin
        rd[i*DATA_W +: DATA_W] = wd_b;
      end else if (hit_a) begin
        rd[i*DATA_W +: DATA_W] = wd_a;
      end else begin
        rd[i*DATA_W +: DATA_W] = stored;
      end
      hazard[i] = (a != PC_A) && ({1'b0, cnt_a} > CW'(nwr));
    end
  end

endmodule
